player_bullet_ctrl: RTL and testbench

Upstream stage of the enemy hit judge. Owns the single player bullet: launches it from the player ship on a fire press, moves it up the screen once per frame tick, and retires it on an off-screen exit or a hit report. Drives the bullet coordinates and bullet-enable that the hit judge samples. Also counts shots fired for the HUD.

---
 rtl/player_bullet_ctrl_pkg.sv | 14 +
 rtl/player_bullet_ctrl_edge_rise.sv | 21 ++
 rtl/player_bullet_ctrl.sv | 102 ++++++++++
 tb/tb_player_bullet_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/player_bullet_ctrl_pkg.sv
// Shared game constants and the bullet lifecycle state encoding.
package player_bullet_ctrl_pkg;

    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned SCREEN_H = 480;
    localparam int unsigned CW       = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FLY  = 2'd1,
        COOL = 2'd2
    } bullet_state_e;

endpackage : player_bullet_ctrl_pkg

// File: rtl/player_bullet_ctrl_edge_rise.sv
// Rising-edge detector: one-cycle pulse on a 0->1 transition of a synchronous level.
module edge_rise (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic pulse
);

    logic d_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign pulse = d & ~d_q;

endmodule : edge_rise

// File: rtl/player_bullet_ctrl.sv
// Player bullet owner: launch on fire edge, climb once per frame tick, retire on exit or hit.
module player_bullet_ctrl
    import player_bullet_ctrl_pkg::*;
#(
    parameter int unsigned CW       = player_bullet_ctrl_pkg::CW,
    parameter int unsigned SPEED    = 8,
    parameter int unsigned X_OFF    = 20,
    parameter int unsigned Y_OFF    = 10,
    parameter int unsigned COOLDOWN = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frame_tick,
    input  logic          fire,
    input  logic [CW-1:0] p_x,
    input  logic [CW-1:0] p_y,
    input  logic          hit,
    output logic [CW-1:0] b_x,
    output logic [CW-1:0] b_y,
    output logic          mybullet_en,
    output logic [7:0]    shot_cnt
);

    localparam int unsigned CNT_W = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN + 1);

    bullet_state_e    state_q;
    logic [CW-1:0]    b_x_q;
    logic [CW-1:0]    b_y_q;
    logic             en_q;
    logic [7:0]       shot_cnt_q;
    logic [CNT_W-1:0] cool_cnt_q;

    logic             fire_rise;
    logic [CW-1:0]    launch_x;
    logic [CW-1:0]    launch_y;
    logic             exits_top;

    edge_rise u_fire_edge (
        .clk   (clk),
        .rst   (rst),
        .d     (fire),
        .pulse (fire_rise)
    );

    // Launch point clamps at the top edge rather than wrapping.
    assign launch_x  = p_x + CW'(X_OFF);
    assign launch_y  = (p_y < CW'(Y_OFF)) ? '0 : p_y - CW'(Y_OFF);
    assign exits_top = b_y_q < CW'(SPEED);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            b_x_q      <= '0;
            b_y_q      <= '0;
            en_q       <= 1'b0;
            shot_cnt_q <= '0;
            cool_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fire_rise) begin
                        state_q    <= FLY;
                        b_x_q      <= launch_x;
                        b_y_q      <= launch_y;
                        en_q       <= 1'b1;
                        shot_cnt_q <= shot_cnt_q + 8'd1;
                    end
                end
                FLY: begin
                    // Hit outranks the tick so a struck bullet never moves on its final cycle.
                    if (hit || (frame_tick && exits_top)) begin
                        state_q    <= COOL;
                        en_q       <= 1'b0;
                        cool_cnt_q <= CNT_W'(COOLDOWN);
                    end else if (frame_tick) begin
                        b_y_q <= b_y_q - CW'(SPEED);
                    end
                end
                COOL: begin
                    if (cool_cnt_q == '0) begin
                        state_q <= IDLE;
                    end else if (frame_tick) begin
                        cool_cnt_q <= cool_cnt_q - CNT_W'(1);
                        if (cool_cnt_q == CNT_W'(1)) begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    en_q    <= 1'b0;
                end
            endcase
        end
    end

    assign b_x         = b_x_q;
    assign b_y         = b_y_q;
    assign mybullet_en = en_q;
    assign shot_cnt    = shot_cnt_q;

endmodule : player_bullet_ctrl

// File: tb/tb_player_bullet_ctrl.sv
// Directed bench for player_bullet_ctrl with an expected-output scoreboard queue.
module tb_player_bullet_ctrl;

    localparam int unsigned CW = 10;

    logic          clk;
    logic          rst;
    logic          frame_tick;
    logic          fire;
    logic [CW-1:0] p_x;
    logic [CW-1:0] p_y;
    logic          hit;
    logic [CW-1:0] b_x;
    logic [CW-1:0] b_y;
    logic          mybullet_en;
    logic [7:0]    shot_cnt;

    typedef struct {
        string         tag;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic          en;
        logic [7:0]    cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_assert;
    int   n_fail;

    player_bullet_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .frame_tick  (frame_tick),
        .fire        (fire),
        .p_x         (p_x),
        .p_y         (p_y),
        .hit         (hit),
        .b_x         (b_x),
        .b_y         (b_y),
        .mybullet_en (mybullet_en),
        .shot_cnt    (shot_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ftick(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            cyc(1);
            frame_tick = 1'b0;
        end
    endtask

    task automatic push_exp(input string tag, input int x, input int y, input bit en, input int cnt);
        exp_t e;
        e.tag = tag;
        e.x   = CW'(x);
        e.y   = CW'(y);
        e.en  = en;
        e.cnt = 8'(cnt);
        exp_q.push_back(e);
    endtask

    task automatic cmp(input string tag, input string fld, input int obs, input int exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s.%s observed=%0d expected=%0d", tag, fld, obs, exp_v);
        end
    endtask

    task automatic check_out();
        exp_t e;
        if (exp_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = exp_q.pop_front();
        cmp(e.tag, "b_x", int'(b_x), int'(e.x));
        cmp(e.tag, "b_y", int'(b_y), int'(e.y));
        cmp(e.tag, "en",  int'(mybullet_en), int'(e.en));
        cmp(e.tag, "cnt", int'(shot_cnt), int'(e.cnt));
    endtask

    initial begin
        n_assert   = 0;
        n_fail     = 0;
        rst        = 1'b1;
        frame_tick = 1'b0;
        fire       = 1'b0;
        hit        = 1'b0;
        p_x        = '0;
        p_y        = '0;
        cyc(2);
        push_exp("reset", 0, 0, 1'b0, 0);
        check_out();
        rst = 1'b0;
        cyc(1);

        // First launch from (100,400)
        p_x = 10'd100; p_y = 10'd400;
        fire = 1'b1;
        push_exp("launch1", 120, 390, 1'b1, 1);
        cyc(1);
        check_out();
        fire = 1'b0;
        cyc(1);

        ftick(1);
        push_exp("tick1", 120, 382, 1'b1, 1);
        check_out();
        ftick(47);
        push_exp("tick48", 120, 6, 1'b1, 1);
        check_out();
        ftick(1);
        push_exp("exit", 120, 6, 1'b0, 1);
        check_out();

        // Fire edges during cooldown are dropped, including with one tick still pending
        fire = 1'b1; cyc(1); fire = 1'b0; cyc(1);
        push_exp("cool_fire", 120, 6, 1'b0, 1);
        check_out();
        ftick(7);
        fire = 1'b1; cyc(1); fire = 1'b0; cyc(1);
        push_exp("cool7_fire", 120, 6, 1'b0, 1);
        check_out();
        ftick(1);

        p_x = 10'd50; p_y = 10'd210;
        fire = 1'b1;
        push_exp("launch2", 70, 200, 1'b1, 2);
        cyc(1);
        check_out();
        fire = 1'b0;
        cyc(1);

        fire = 1'b1; cyc(1); fire = 1'b0; cyc(1);
        push_exp("fly_fire", 70, 200, 1'b1, 2);
        check_out();

        hit = 1'b1;
        push_exp("hit", 70, 200, 1'b0, 2);
        cyc(1);
        check_out();
        hit = 1'b0;
        cyc(1);
        hit = 1'b1; cyc(1); hit = 1'b0; cyc(1);
        push_exp("hit_in_cool", 70, 200, 1'b0, 2);
        check_out();
        ftick(8);

        // Player moves after launch; hit and tick coincide
        p_x = 10'd10; p_y = 10'd310;
        fire = 1'b1; cyc(1); fire = 1'b0;
        push_exp("launch3", 30, 300, 1'b1, 3);
        check_out();
        p_x = 10'd500; p_y = 10'd0;
        cyc(1);
        hit = 1'b1; frame_tick = 1'b1;
        push_exp("hit_tick", 30, 300, 1'b0, 3);
        cyc(1);
        check_out();
        hit = 1'b0; frame_tick = 1'b0;
        ftick(8);

        // Held fire across flight, cooldown and idle launches once; clamp at top edge
        p_x = 10'd0; p_y = 10'd5;
        fire = 1'b1;
        cyc(1);
        push_exp("launch_clamp", 20, 0, 1'b1, 4);
        check_out();
        ftick(1);
        push_exp("clamp_exit", 20, 0, 1'b0, 4);
        check_out();
        ftick(8);
        cyc(990);
        push_exp("hold_fire", 20, 0, 1'b0, 4);
        check_out();
        fire = 1'b0;
        cyc(1);

        // Async reset between clock edges during flight
        p_x = 10'd100; p_y = 10'd400;
        fire = 1'b1; cyc(1); fire = 1'b0;
        push_exp("launch5", 120, 390, 1'b1, 5);
        check_out();
        #2;
        rst = 1'b1;
        #1;
        push_exp("async_rst", 0, 0, 1'b0, 0);
        check_out();
        cyc(2);
        rst = 1'b0;
        cyc(1);
        push_exp("post_rst", 0, 0, 1'b0, 0);
        check_out();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_player_bullet_ctrl
